// File: rtl/elixirchip_es1_spu_op_mem_reader_if.sv
// Bus bundle for elixirchip_es1_spu_op_mem_reader.
//
// Groups the three handshake groups of the burst reader:
//   command   : s_cmd_addr, s_cmd_len, s_cmd_valid -> s_cmd_ready
//   memory    : m_raddr, m_rvalid -> memory, s_rdata <- memory
//   stream    : m_data, m_valid, m_last, plus busy status
//
// modport master : the reader itself (accepts commands, drives memory
//                  requests and the output stream)
// modport slave  : the surrounding environment (command source, memory,
//                  stream sink)
interface elixirchip_es1_spu_op_mem_reader_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned LEN_BITS  = 9
);
    logic [ADDR_BITS-1:0] s_cmd_addr;
    logic [LEN_BITS-1:0]  s_cmd_len;
    logic                 s_cmd_valid;
    logic                 s_cmd_ready;

    logic [ADDR_BITS-1:0] m_raddr;
    logic                 m_rvalid;
    logic [DATA_BITS-1:0] s_rdata;

    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 busy;

    modport master (
        input  s_cmd_addr, s_cmd_len, s_cmd_valid, s_rdata,
        output s_cmd_ready, m_raddr, m_rvalid, m_data, m_valid, m_last, busy
    );

    modport slave (
        output s_cmd_addr, s_cmd_len, s_cmd_valid, s_rdata,
        input  s_cmd_ready, m_raddr, m_rvalid, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/elixirchip_es1_spu_op_mem_reader.sv
// elixirchip_es1_spu_op_mem_reader
//
// Burst memory reader. A command (start address, length-1) is accepted in
// IDLE; the reader then issues one read request per cke cycle with an
// address that wraps modulo 2^ADDR_BITS, and streams the returned words out
// in issue order, flagging the final word with m_last.
//
// Ports:
//   reset : synchronous, active-high; overrides cke and aborts any burst
//   clk   : rising-edge clock
//   cke   : clock enable; when low every register holds
//   bus   : master view of elixirchip_es1_spu_op_mem_reader_if
//           (command handshake, memory request/return, output stream, busy)
//
// Parameters:
//   RLATENCY  : read latency of the attached memory in cke cycles (1..8)
//   DATA_BITS : read data width
//   ADDR_BITS : memory address width
//   LEN_BITS  : burst length field width
//   DEVICE, SIMULATION, DEBUG : accepted for instantiation compatibility only
module elixirchip_es1_spu_op_mem_reader #(
    parameter int unsigned RLATENCY   = 1,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ADDR_BITS  = 9,
    parameter int unsigned LEN_BITS   = 9,
    parameter string       DEVICE     = "RTL",
    parameter string       SIMULATION = "false",
    parameter string       DEBUG      = "false"
) (
    input  logic reset,
    input  logic clk,
    input  logic cke,
    elixirchip_es1_spu_op_mem_reader_if.master bus
);

    // DEVICE/SIMULATION/DEBUG select nothing in this implementation.
    if (DEVICE == "" && SIMULATION == "" && DEBUG == "") begin : g_compat_params
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] addr;
    logic [LEN_BITS-1:0]  remaining;
    logic                 req_last;

    // One bit per cke cycle of memory latency. The pipe is fed from the
    // registered request (m_rvalid/req_last), so its output stage lines up
    // with s_rdata RLATENCY cke cycles after the request was presented.
    logic [RLATENCY-1:0]  pipe_valid;
    logic [RLATENCY-1:0]  pipe_last;

    logic                 out_valid;
    logic                 out_last;

    always_comb begin
        out_valid = pipe_valid[RLATENCY-1];
        out_last  = pipe_last[RLATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            addr            <= '0;
            remaining       <= '0;
            req_last        <= 1'b0;
            pipe_valid      <= '0;
            pipe_last       <= '0;
            bus.s_cmd_ready <= 1'b1;
            bus.busy        <= 1'b0;
            bus.m_rvalid    <= 1'b0;
            bus.m_raddr     <= '0;
            bus.m_valid     <= 1'b0;
            bus.m_last      <= 1'b0;
            bus.m_data      <= '0;
        end else if (cke) begin
            pipe_valid <= RLATENCY'({pipe_valid, bus.m_rvalid});
            pipe_last  <= RLATENCY'({pipe_last, req_last});

            if (out_valid) begin
                bus.m_data  <= bus.s_rdata;
                bus.m_valid <= 1'b1;
                bus.m_last  <= out_last;
            end else begin
                bus.m_valid <= 1'b0;
                bus.m_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bus.m_rvalid <= 1'b0;
                    req_last     <= 1'b0;
                    // s_cmd_ready is high throughout IDLE, so valid alone
                    // completes the handshake here.
                    if (bus.s_cmd_valid) begin
                        addr            <= bus.s_cmd_addr;
                        remaining       <= bus.s_cmd_len;
                        state           <= ISSUE;
                        bus.s_cmd_ready <= 1'b0;
                        bus.busy        <= 1'b1;
                    end
                end

                ISSUE: begin
                    bus.m_rvalid <= 1'b1;
                    bus.m_raddr  <= addr;
                    addr         <= addr + ADDR_BITS'(1);
                    remaining    <= remaining - LEN_BITS'(1);
                    req_last     <= (remaining == '0);
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    bus.m_rvalid <= 1'b0;
                    req_last     <= 1'b0;
                    // Leave on the same edge that registers m_last.
                    if (out_valid && out_last) begin
                        state           <= IDLE;
                        bus.s_cmd_ready <= 1'b1;
                        bus.busy        <= 1'b0;
                    end
                end

                default: begin
                    state           <= IDLE;
                    bus.m_rvalid    <= 1'b0;
                    req_last        <= 1'b0;
                    bus.s_cmd_ready <= 1'b1;
                    bus.busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_reader.sv
// Testbench for elixirchip_es1_spu_op_mem_reader: two instances (read
// latency 1 and 3) each with a behavioural memory returning data[a]=a[7:0].
// A queue-based model predicts every request address and every output word
// with its due cke cycle.
module tb_elixirchip_es1_spu_op_mem_reader;
    localparam int unsigned AW   = 9;
    localparam int unsigned LW   = 9;
    localparam int unsigned DW   = 8;
    localparam int unsigned RL_A = 1;
    localparam int unsigned RL_B = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [1:0]    cmd_valid;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_mem_reader_if #(.DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) b1 ();
    elixirchip_es1_spu_op_mem_reader_if #(.DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)) b3 ();

    assign b1.s_cmd_addr  = cmd_addr;
    assign b1.s_cmd_len   = cmd_len;
    assign b1.s_cmd_valid = cmd_valid[0];
    assign b3.s_cmd_addr  = cmd_addr;
    assign b3.s_cmd_len   = cmd_len;
    assign b3.s_cmd_valid = cmd_valid[1];

    elixirchip_es1_spu_op_mem_reader #(
        .RLATENCY(RL_A), .DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)
    ) u_dut_a (
        .reset(reset), .clk(clk), .cke(cke), .bus(b1.master)
    );

    elixirchip_es1_spu_op_mem_reader #(
        .RLATENCY(RL_B), .DATA_BITS(DW), .ADDR_BITS(AW), .LEN_BITS(LW)
    ) u_dut_b (
        .reset(reset), .clk(clk), .cke(cke), .bus(b3.master)
    );

    // Behavioural memories: data[a] = a[7:0], RL cke cycles of latency.
    logic [DW-1:0] mem_a_q;
    logic [DW-1:0] mem_b_q [RL_B];

    always @(posedge clk) begin
        if (cke) mem_a_q <= b1.m_raddr[DW-1:0];
    end

    always @(posedge clk) begin
        if (cke) begin
            mem_b_q[0] <= b3.m_raddr[DW-1:0];
            mem_b_q[1] <= mem_b_q[0];
            mem_b_q[2] <= mem_b_q[1];
        end
    end

    assign b1.s_rdata = mem_a_q;
    assign b3.s_rdata = mem_b_q[RL_B-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } req_t;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    req_t        req_q [2][$];
    word_t       out_q [2][$];
    int unsigned cyc [2];
    int unsigned rv_cnt [2];
    logic        acc [2];
    logic [21:0] pre_snap [2];
    logic        e_cke;
    logic        e_rst;
    bit          rand_cke = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned rl(input int d);
        return (d == 0) ? RL_A : RL_B;
    endfunction

    function automatic string tag(input int d, input string name);
        return $sformatf("rl%0d_%s", rl(d), name);
    endfunction

    // {m_raddr, m_rvalid, m_data, m_valid, m_last, s_cmd_ready, busy}
    function automatic logic [21:0] snap(input int d);
        if (d == 0)
            return {b1.m_raddr, b1.m_rvalid, b1.m_data, b1.m_valid, b1.m_last, b1.s_cmd_ready, b1.busy};
        return {b3.m_raddr, b3.m_rvalid, b3.m_data, b3.m_valid, b3.m_last, b3.s_cmd_ready, b3.busy};
    endfunction

    task automatic monitor(input int d);
        logic [21:0]   s;
        logic [AW-1:0] raddr;
        logic [DW-1:0] dat;
        logic          rv, v, l, rdy, bsy;
        logic          exp_rv, exp_v, exp_rdy;
        req_t          r;
        word_t         w;
        s = snap(d);
        {raddr, rv, dat, v, l, rdy, bsy} = s;
        acc[d] = 1'b0;
        if (e_rst) begin
            check(tag(d, "reset_state"), 32'(s), 32'(22'h2));
            req_q[d].delete();
            out_q[d].delete();
            return;
        end
        if (!e_cke) begin
            check(tag(d, "cke_hold"), 32'(s), 32'(pre_snap[d]));
            return;
        end
        cyc[d]++;

        exp_rv = (req_q[d].size() != 0);
        check(tag(d, "m_rvalid"), 32'(rv), 32'(exp_rv));
        if (exp_rv) begin
            r = req_q[d].pop_front();
            check(tag(d, "m_raddr"), 32'(raddr), 32'(r.addr));
            rv_cnt[d]++;
            w.due  = cyc[d] + rl(d) + 1;
            w.data = r.addr[DW-1:0];
            w.last = r.last;
            out_q[d].push_back(w);
        end

        exp_v = (out_q[d].size() != 0) && (out_q[d][0].due == cyc[d]);
        check(tag(d, "m_valid"), 32'(v), 32'(exp_v));
        if (exp_v) begin
            w = out_q[d].pop_front();
            check(tag(d, "m_data"), 32'(dat), 32'(w.data));
            check(tag(d, "m_last"), 32'(l), 32'(w.last));
        end else begin
            check(tag(d, "m_last_idle"), 32'(l), 32'd0);
            check(tag(d, "m_data_hold"), 32'(dat), 32'(pre_snap[d][11:4]));
        end

        if (cmd_valid[d] && pre_snap[d][1]) begin
            acc[d] = 1'b1;
            for (int unsigned i = 0; i <= 32'(cmd_len); i++) begin
                r.addr = AW'(32'(cmd_addr) + i);
                r.last = (i == 32'(cmd_len));
                req_q[d].push_back(r);
            end
        end

        exp_rdy = (req_q[d].size() == 0) && (out_q[d].size() == 0);
        check(tag(d, "s_cmd_ready"), 32'(rdy), 32'(exp_rdy));
        check(tag(d, "busy"), 32'(bsy), 32'(!exp_rdy));
    endtask

    task automatic step();
        if (rand_cke) cke = ($urandom_range(0, 9) != 0);
        e_cke = cke;
        e_rst = reset;
        for (int d = 0; d < 2; d++) pre_snap[d] = snap(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) monitor(d);
    endtask

    function automatic bit idle(input int d);
        return (req_q[d].size() == 0) && (out_q[d].size() == 0) &&
               (snap(d)[1] == 1'b1) && (cmd_valid[d] == 1'b0);
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(idle(0) && idle(1)) && n < budget) begin
            step();
            n++;
        end
        check("wait_idle", 32'(idle(0) && idle(1)), 32'd1);
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] len);
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 2'b11;
        for (int n = 0; n < 300 && cmd_valid != 2'b00; n++) begin
            step();
            for (int d = 0; d < 2; d++) if (acc[d]) cmd_valid[d] = 1'b0;
        end
        check("cmd_accept", 32'(cmd_valid), 32'd0);
        cmd_valid = 2'b00;
    endtask

    initial begin
        int acc_cnt [2];
        int unsigned base;
        int n;

        reset     = 1'b1;
        cke       = 1'b1;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_valid = 2'b00;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Directed bursts: plain, address wrap, single word.
        send_cmd(9'h010, 9'd3);
        wait_idle(50);
        send_cmd(9'h1FE, 9'd3);
        wait_idle(50);
        send_cmd(9'h055, 9'd0);
        wait_idle(50);

        // Command valid held high across a burst: second command only
        // after return to IDLE.
        cmd_addr   = 9'h020;
        cmd_len    = 9'd4;
        cmd_valid  = 2'b11;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        for (int i = 0; i < 300 && cmd_valid != 2'b00; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (acc[d]) begin
                    acc_cnt[d]++;
                    cmd_addr = 9'h100;
                    if (acc_cnt[d] == 2) cmd_valid[d] = 1'b0;
                end
            end
        end
        check("held_cmd_done", 32'(cmd_valid), 32'd0);
        cmd_valid = 2'b00;
        wait_idle(100);

        // Reset (with cke low) after two of eight requests have issued.
        base = rv_cnt[1];
        send_cmd(9'h0A0, 9'd7);
        n = 0;
        while (rv_cnt[1] < base + 2 && n < 20) begin
            step();
            n++;
        end
        check("abort_two_issued", rv_cnt[1] - base, 32'd2);
        reset = 1'b1;
        cke   = 1'b0;
        step();
        reset = 1'b0;
        cke   = 1'b1;
        for (int i = 0; i < 10; i++) step();
        wait_idle(20);

        // Random cke (~10% low), including a wrapping burst.
        rand_cke = 1'b1;
        send_cmd(9'h1F8, 9'd15);
        wait_idle(400);
        for (int i = 0; i < 8; i++) begin
            send_cmd(AW'($urandom_range(0, 511)), (i < 3) ? 9'd15 : LW'($urandom_range(0, 20)));
            wait_idle(400);
        end
        rand_cke = 1'b0;
        cke      = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
